// File: rtl/seven_pkg.sv
// Shared constants for the seven-segment bus: segment indices, glyph table,
// and the receive-side FSM state type.
package seven_pkg;

    // Bus indices on segments[0:7]
    localparam int SEG_DP = 0;
    localparam int SEG_A  = 1;
    localparam int SEG_B  = 2;
    localparam int SEG_C  = 3;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 5;
    localparam int SEG_F  = 6;
    localparam int SEG_G  = 7;

    // Glyphs as abcdefg, lit = 1, a in bit 6; entry i is hex digit i
    localparam logic [0:15][6:0] GLYPHS = {
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    localparam logic [6:0] BLANK_GLYPH = 7'b0000000;

    typedef enum logic {
        SETTLING = 1'b0,
        STABLE   = 1'b1
    } rd_state_t;

    // Repack the bus into {dp, a, b, c, d, e, f, g} with dp in bit 7
    function automatic logic [7:0] to_pat(input logic [0:7] s);
        to_pat = {s[SEG_DP], s[SEG_A], s[SEG_B], s[SEG_C],
                  s[SEG_D], s[SEG_E], s[SEG_F], s[SEG_G]};
    endfunction

endpackage

// File: rtl/seven_decode.sv
// Combinational glyph decoder: 7-bit lit abcdefg pattern -> hex digit.
// Ports: glyph in [6:0]; digit out [3:0]; hit = glyph is in the table;
// blank = all segments off.
module seven_decode
    import seven_pkg::*;
(
    input  logic [6:0] glyph,
    output logic [3:0] digit,
    output logic       hit,
    output logic       blank
);

    always_comb begin
        digit = 4'd0;
        hit   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (glyph == GLYPHS[i]) begin
                digit = 4'(i);
                hit   = 1'b1;
            end
        end
        blank = (glyph == BLANK_GLYPH);
    end

endmodule

// File: rtl/seven_reader.sv
// Receive side of the 8-line seven-segment bus: synchronise, filter, decode.
// Ports: clk, rst (sync, active high), segments[0:7] raw bus; registered
// outputs value, dp, blank, invalid, stable and a one-cycle valid pulse.
module seven_reader
    import seven_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:7] segments,
    output logic [3:0] value,
    output logic       dp,
    output logic       blank,
    output logic       invalid,
    output logic       stable,
    output logic       valid
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CSAT = CW'(STABLE_CYCLES);

    // Patterns are kept as {dp, a..g} with lit = 1 from the first flop on,
    // so the all-off reset value is simply zero.
    logic [7:0] raw_pat;
    logic [7:0] lit_in;

    logic [SYNC_STAGES-1:0][7:0] sync;
    logic [7:0] samp;
    logic [7:0] prev;
    logic [7:0] committed;

    rd_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic          commit;
    logic          change;

    logic [3:0] dec_digit;
    logic       dec_hit;
    logic       dec_blank;

    assign raw_pat = to_pat(segments);
    assign lit_in  = (ACTIVE_LOW != 0) ? ~raw_pat : raw_pat;
    assign samp    = sync[SYNC_STAGES-1];

    seven_decode u_decode (
        .glyph (samp[6:0]),
        .digit (dec_digit),
        .hit   (dec_hit),
        .blank (dec_blank)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cnt_inc = (cnt == CSAT) ? cnt : cnt + 1'b1;
        commit  = 1'b0;
        if (samp != prev) begin
            state_n = SETTLING;
            cnt_n   = '0;
        end else if (state == SETTLING) begin
            cnt_n = cnt_inc;
            if (cnt_inc >= CMAX) begin
                commit  = 1'b1;
                state_n = STABLE;
            end
        end
    end

    // Re-settling onto the pattern already shown must stay silent
    assign change = commit && (samp != committed);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= '0;
            prev      <= '0;
            committed <= '0;
            state     <= SETTLING;
            cnt       <= '0;
            value     <= 4'd0;
            dp        <= 1'b0;
            blank     <= 1'b1;
            invalid   <= 1'b0;
            valid     <= 1'b0;
        end else begin
            sync[0] <= lit_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
            prev  <= samp;
            state <= state_n;
            cnt   <= cnt_n;
            valid <= change;
            if (change) begin
                committed <= samp;
                dp        <= samp[7];
                blank     <= dec_blank;
                invalid   <= !dec_hit && !dec_blank;
                if (dec_hit) begin
                    value <= dec_digit;
                end
            end
        end
    end

    assign stable = (state == STABLE);

endmodule
